// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary processing element: control
// encodings and the partial-sum width multiplier.
package pe_pkg;

   localparam logic [1:0] CTRL_IDLE    = 2'b00;
   localparam logic [1:0] CTRL_LOAD    = 2'b01;
   localparam logic [1:0] CTRL_COMPUTE = 2'b10;
   localparam logic [1:0] CTRL_RSVD    = 2'b11;

   localparam int PSUM_WIDTH_MULT = 4;

   function automatic int psum_width(input int word_width);
      return word_width * PSUM_WIDTH_MULT;
   endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: o_sum = i_d + zext(i_a * i_w), unsigned,
// wrapping modulo 2^(4W).
module pe_mac
   import pe_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic [WORD_WIDTH-1:0]                 i_a,
   input  logic [WORD_WIDTH-1:0]                 i_w,
   input  logic [WORD_WIDTH*PSUM_WIDTH_MULT-1:0] i_d,
   output logic [WORD_WIDTH*PSUM_WIDTH_MULT-1:0] o_sum
);

   localparam int PW = WORD_WIDTH * PSUM_WIDTH_MULT;
   localparam int XW = 2 * WORD_WIDTH;

   logic [XW-1:0] w_prod;
   logic [PW-1:0] w_prod_ext;

   assign w_prod     = XW'(i_a) * XW'(i_w);
   assign w_prod_ext = {{(PW-XW){1'b0}}, w_prod};
   assign o_sum      = i_d + w_prod_ext;

endmodule

// File: rtl/ws_processing_element.sv
// Weight-stationary systolic PE with fully registered outputs.
// Optional macro PE_CONTROL_OUT_EN adds a registered control_out for diagonal control ripple.
module ws_processing_element
   import pe_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [1:0]                            control,
   input  logic [WORD_WIDTH-1:0]                 a_in,
   input  logic [WORD_WIDTH*PSUM_WIDTH_MULT-1:0] d_in,
`ifdef PE_CONTROL_OUT_EN
   output logic [1:0]                            control_out,
`endif
   output logic [WORD_WIDTH-1:0]                 a_out,
   output logic [WORD_WIDTH*PSUM_WIDTH_MULT-1:0] d_out
);

   localparam int W  = WORD_WIDTH;
   localparam int PW = WORD_WIDTH * PSUM_WIDTH_MULT;

   logic [W-1:0]  r_weight;
   logic [W-1:0]  r_a_out;
   logic [PW-1:0] r_d_out;
   logic [PW-1:0] w_mac_sum;

   pe_mac #(
      .WORD_WIDTH (W)
   ) u_mac (
      .i_a   (a_in),
      .i_w   (r_weight),
      .i_d   (d_in),
      .o_sum (w_mac_sum)
   );

   // IDLE and reserved force zeros so X on the inputs never reaches neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_weight <= '0;
         r_a_out  <= '0;
         r_d_out  <= '0;
      end else begin
         case (control)
            CTRL_LOAD: begin
               r_weight <= d_in[W-1:0];
               r_a_out  <= '0;
               r_d_out  <= {{(PW-W){1'b0}}, r_weight};
            end
            CTRL_COMPUTE: begin
               r_a_out  <= a_in;
               r_d_out  <= w_mac_sum;
            end
            default: begin
               r_a_out  <= '0;
               r_d_out  <= '0;
            end
         endcase
      end
   end

   assign a_out = r_a_out;
   assign d_out = r_d_out;

`ifdef PE_CONTROL_OUT_EN
   logic [1:0] r_control_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_control_out <= CTRL_IDLE;
      end else begin
         r_control_out <= control;
      end
   end

   assign control_out = r_control_out;
`endif

endmodule

// File: tb/tb_ws_processing_element.sv
// Self-checking bench for ws_processing_element: directed scenarios plus a
// randomized run against a behavioural model of the PE.
module tb_ws_processing_element;

   localparam int W  = 8;
   localparam int PW = 4 * W;

   logic          clk;
   logic          reset_n;
   logic [1:0]    control;
   logic [W-1:0]  a_in;
   logic [PW-1:0] d_in;
   logic [W-1:0]  a_out;
   logic [PW-1:0] d_out;
`ifdef PE_CONTROL_OUT_EN
   logic [1:0]    control_out;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   logic [W-1:0]  m_weight;
   logic [W-1:0]  m_a;
   logic [PW-1:0] m_d;
   logic [1:0]    m_ctrl;

   ws_processing_element #(.WORD_WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .control     (control),
      .a_in        (a_in),
      .d_in        (d_in),
`ifdef PE_CONTROL_OUT_EN
      .control_out (control_out),
`endif
      .a_out       (a_out),
      .d_out       (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs, advance one rising edge, sample 1ns later, update the model.
   task automatic cycle(input logic [1:0] c, input logic [W-1:0] a, input logic [PW-1:0] d);
      longint unsigned sum;
      control = c;
      a_in    = a;
      d_in    = d;
      case (c)
         2'b01: begin
            m_d      = PW'(m_weight);
            m_a      = '0;
            m_weight = d[W-1:0];
         end
         2'b10: begin
            sum = longint'(d) + longint'(a) * longint'(m_weight);
            m_d = sum[PW-1:0];
            m_a = a;
         end
         default: begin
            m_d = '0;
            m_a = '0;
         end
      endcase
      m_ctrl = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      control = 2'b00; a_in = '0; d_in = '0;
      m_weight = '0; m_a = '0; m_d = '0; m_ctrl = 2'b00;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      // Load a weight and compute so outputs are non-zero before reset.
      cycle(2'b01, 8'd0, 32'd9);
      cycle(2'b10, 8'd3, 32'd1);
      chk("pre_reset_d", d_out, 32'd28);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_a", PW'(a_out), '0);
      chk("async_reset_d", d_out, '0);
      m_weight = '0; m_a = '0; m_d = '0; m_ctrl = 2'b00;
      #1 reset_n = 1'b1;
      cycle(2'b00, 8'd0, 32'd0);
      chk("post_reset_idle_a", PW'(a_out), '0);
      chk("post_reset_idle_d", d_out, '0);
      // Weight was cleared by reset: compute passes d_in through unchanged.
      cycle(2'b10, 8'd3, 32'd1);
      chk("weight_cleared_d", d_out, 32'd1);
      chk("weight_cleared_a", PW'(a_out), 32'd3);
   endtask

   task automatic test_weight_shift();
      cycle(2'b01, 8'd0, 32'd3);
      chk("shift_0", d_out, 32'd0);
      chk("shift_a0", PW'(a_out), '0);
      cycle(2'b01, 8'd0, 32'd4);
      chk("shift_3", d_out, 32'd3);
      cycle(2'b01, 8'd0, 32'd5);
      chk("shift_4", d_out, 32'd4);
   endtask

   task automatic test_compute();
      cycle(2'b10, 8'd2, 32'd4);
      chk("compute_a", PW'(a_out), 32'd2);
      chk("compute_d", d_out, 32'd14);
      for (int i = 0; i < 2; i++) begin
         cycle(2'b10, 8'd2, 32'd4);
         chk("compute_hold_d", d_out, 32'd14);
      end
   endtask

   task automatic test_reserved_idle();
      cycle(2'b11, 8'd7, 32'h1234);
      chk("rsvd_a", PW'(a_out), '0);
      chk("rsvd_d", d_out, '0);
      cycle(2'b00, 8'hx, 32'hx);
      chk("idle_x_a", PW'(a_out), '0);
      chk("idle_x_d", d_out, '0);
      cycle(2'b10, 8'd1, 32'd0);
      chk("weight_retained_d", d_out, 32'd5);
   endtask

   task automatic test_overflow();
      cycle(2'b01, 8'd0, 32'd255);
      chk("ovf_load_shift", d_out, 32'd5);
      cycle(2'b10, 8'd255, 32'hFFFF_FFFF);
      chk("ovf_d", d_out, 32'h0000_FE00);
      chk("ovf_a", PW'(a_out), 32'd255);
   endtask

   task automatic test_random();
      logic [1:0]    c;
      logic [W-1:0]  a;
      logic [PW-1:0] d;
      for (int i = 0; i < 300; i++) begin
         c = 2'($urandom_range(0, 3));
         a = W'($urandom);
         d = (i % 4 == 0) ? PW'($urandom_range(0, 255)) : PW'($urandom);
         cycle(c, a, d);
         chk("rand_a", PW'(a_out), PW'(m_a));
         chk("rand_d", d_out, m_d);
`ifdef PE_CONTROL_OUT_EN
         chk("rand_ctrl_out", PW'(control_out), PW'(m_ctrl));
`endif
      end
   endtask

`ifdef PE_CONTROL_OUT_EN
   task automatic test_control_out();
      logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 4; i++) begin
         cycle(seq[i], 8'd0, 32'd0);
         chk("ctrl_out_seq", PW'(control_out), PW'(seq[i]));
      end
      #2 reset_n = 1'b0;
      #1;
      chk("ctrl_out_reset", PW'(control_out), '0);
      m_weight = '0; m_a = '0; m_d = '0; m_ctrl = 2'b00;
      #1 reset_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_weight_shift();
      test_compute();
      test_reserved_idle();
      test_overflow();
      test_random();
`ifdef PE_CONTROL_OUT_EN
      test_control_out();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
